// File: rtl/trans_packer.sv
// Packs PACK_RATIO narrow valid/ready beats into one wide word with per-lane keep.
// A word closes when full, on in_last, or after FLUSH_TIMEOUT idle cycles.
module trans_packer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned PACK_RATIO    = 4,
  parameter int unsigned FLUSH_TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [PACK_RATIO*DATA_WIDTH-1:0] out_data,
  output logic [PACK_RATIO-1:0]            out_keep,
  output logic                             out_last,
  input  logic                             out_ready
);

  localparam int unsigned LW = $clog2(PACK_RATIO);
  localparam int unsigned IW = (FLUSH_TIMEOUT == 0) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [LW-1:0] LAST_LANE = LW'(PACK_RATIO - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(FLUSH_TIMEOUT);

  logic [LW-1:0]                  lane_cnt_q, lane_cnt_d;
  logic [IW-1:0]                  idle_cnt_q, idle_cnt_d;
  logic [PACK_RATIO*DATA_WIDTH-1:0] acc_data_q, acc_data_d, acc_data_m;
  logic [PACK_RATIO-1:0]          acc_keep_q, acc_keep_d, acc_keep_m;
  logic                           out_valid_q, out_valid_d;
  logic [PACK_RATIO*DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [PACK_RATIO-1:0]          out_keep_q, out_keep_d;
  logic                           out_last_q, out_last_d;

  logic out_free, insert, remove, close_ins, flush, close;

  assign out_free  = !out_valid_q || out_ready;
  assign in_ready  = !rst && out_free;
  assign insert    = in_valid && in_ready;
  assign remove    = out_valid_q && out_ready;
  assign close_ins = insert && ((lane_cnt_q == LAST_LANE) || in_last);
  assign flush     = (FLUSH_TIMEOUT != 0) && (lane_cnt_q != '0) &&
                     (idle_cnt_q == IDLE_MAX) && !insert && out_free;
  assign close     = close_ins || flush;

  // Accumulator with the incoming beat already merged into its lane.
  always_comb begin
    acc_data_m = acc_data_q;
    acc_keep_m = acc_keep_q;
    for (int unsigned i = 0; i < PACK_RATIO; i++) begin
      if (insert && (lane_cnt_q == LW'(i))) begin
        acc_data_m[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
        acc_keep_m[i]                          = 1'b1;
      end
    end
  end

  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    acc_data_d  = acc_data_q;
    acc_keep_d  = acc_keep_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    idle_cnt_d  = idle_cnt_q;

    if (close) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_data_m;
      out_keep_d  = acc_keep_m;
      out_last_d  = insert && in_last;
      acc_data_d  = '0;
      acc_keep_d  = '0;
      lane_cnt_d  = '0;
    end else begin
      if (remove) out_valid_d = 1'b0;
      if (insert) begin
        acc_data_d = acc_data_m;
        acc_keep_d = acc_keep_m;
        lane_cnt_d = lane_cnt_q + LW'(1);
      end
    end

    // The accept cycle itself counts as the first idle cycle, so a flush
    // fires FLUSH_TIMEOUT cycles after the last accepted beat.
    if (lane_cnt_d == '0) begin
      idle_cnt_d = '0;
    end else if (insert) begin
      idle_cnt_d = (FLUSH_TIMEOUT == 0) ? '0 : IW'(1);
    end else if (idle_cnt_q != IDLE_MAX) begin
      idle_cnt_d = idle_cnt_q + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_trans_packer.sv
// Directed bench for trans_packer: one instance with the default timeout,
// a second with the timeout disabled.
module tb_trans_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_last, in_ready;
  logic [31:0]  in_data;
  logic         out_valid, out_last, out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_keep;

  logic         n_valid, n_last, n_in_ready;
  logic [31:0]  n_data;
  logic         n_out_valid, n_out_last;
  logic [127:0] n_out_data;
  logic [3:0]   n_out_keep;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  trans_packer #(.DATA_WIDTH(32), .PACK_RATIO(4), .FLUSH_TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .out_ready(out_ready)
  );

  trans_packer #(.DATA_WIDTH(32), .PACK_RATIO(4), .FLUSH_TIMEOUT(0)) u_nt (
    .clk(clk), .rst(rst),
    .in_valid(n_valid), .in_data(n_data), .in_last(n_last), .in_ready(n_in_ready),
    .out_valid(n_out_valid), .out_data(n_out_data), .out_keep(n_out_keep),
    .out_last(n_out_last), .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int highs;
    logic [127:0] held;

    rst = 1'b1; out_ready = 1'b1;
    idle();
    n_valid = 1'b0; n_data = '0; n_last = 1'b0;
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_keep", out_keep, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;

    // Back-to-back full words
    for (int i = 0; i < 8; i++) begin
      beat(i, 1'b0);
      #1 chk("s1_in_ready", in_ready, 1);
      step();
      if (i == 3 || i == 7) begin
        chk("s1_valid", out_valid, 1);
        chk("s1_data", out_data, (i == 3) ? {32'd3, 32'd2, 32'd1, 32'd0}
                                          : {32'd7, 32'd6, 32'd5, 32'd4});
        chk("s1_keep", out_keep, 4'hF);
        chk("s1_last", out_last, 0);
      end else begin
        chk("s1_valid_low", out_valid, 0);
      end
    end
    idle(); step();
    chk("s1_drain", out_valid, 0);

    // Early close on in_last, then next beat in lane 0
    beat(32'hA, 1'b0); step();
    beat(32'hB, 1'b0); step();
    chk("s2_not_yet", out_valid, 0);
    beat(32'hC, 1'b1); step();
    chk("s2_valid", out_valid, 1);
    chk("s2_data", out_data, {32'h0, 32'hC, 32'hB, 32'hA});
    chk("s2_keep", out_keep, 4'b0111);
    chk("s2_last", out_last, 1);
    beat(32'hD, 1'b1); step();
    chk("s2_lane0_data", out_data, {32'h0, 32'h0, 32'h0, 32'hD});
    chk("s2_lane0_keep", out_keep, 4'b0001);
    idle(); step();

    // Timeout flush: accept 0x22 in cycle c, out_valid from cycle c+17
    beat(32'h11, 1'b0); step();
    beat(32'h22, 1'b0); step();
    idle();
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk("s3_flush_delay", n, 16);
    chk("s3_data", out_data, {32'h0, 32'h0, 32'h22, 32'h11});
    chk("s3_keep", out_keep, 4'b0011);
    chk("s3_last", out_last, 0);
    step();

    // Beat arriving when the timer is saturated wins over the flush
    beat(32'h33, 1'b0); step();
    beat(32'h44, 1'b0); step();
    idle();
    for (int i = 0; i < 15; i++) step();
    chk("s3b_no_early_flush", out_valid, 0);
    beat(32'h55, 1'b1); step();
    chk("s3b_valid", out_valid, 1);
    chk("s3b_data", out_data, {32'h0, 32'h55, 32'h44, 32'h33});
    chk("s3b_keep", out_keep, 4'b0111);
    idle(); step();

    // Backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(32'h100 + i, 1'b0); step();
    end
    chk("s4_valid", out_valid, 1);
    held = out_data;
    chk("s4_word0", out_data, {32'h103, 32'h102, 32'h101, 32'h100});
    beat(32'h104, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("s4_in_ready_low", in_ready, 0);
      step();
      chk("s4_data_stable", out_data, held);
      chk("s4_valid_held", out_valid, 1);
    end
    out_ready = 1'b1;
    #1 chk("s4_in_ready_high", in_ready, 1);
    step();
    chk("s4_removed", out_valid, 0);
    for (int i = 5; i < 8; i++) begin
      beat(32'h100 + i, 1'b0); step();
    end
    chk("s4_word1_valid", out_valid, 1);
    chk("s4_word1", out_data, {32'h107, 32'h106, 32'h105, 32'h104});
    idle(); step();

    // Reset mid-word
    for (int i = 1; i < 4; i++) begin
      beat(i, 1'b0); step();
    end
    rst = 1'b1;
    beat(32'h99, 1'b0);
    #1 chk("s5_in_ready_rst", in_ready, 0);
    step();
    chk("s5_rst_valid", out_valid, 0);
    chk("s5_rst_data", out_data, 0);
    chk("s5_rst_keep", out_keep, 0);
    chk("s5_rst_last", out_last, 0);
    rst = 1'b0;
    for (int i = 10; i < 14; i++) begin
      beat(i, 1'b0); step();
      if (i < 13) chk("s5_no_stale_close", out_valid, 0);
    end
    chk("s5_valid", out_valid, 1);
    chk("s5_data", out_data, {32'd13, 32'd12, 32'd11, 32'd10});
    chk("s5_keep", out_keep, 4'hF);
    idle(); step();

    // Timeout disabled
    n_valid = 1'b1; n_data = 32'hE0; n_last = 1'b0; step();
    n_data = 32'hE1; step();
    n_valid = 1'b0; n_data = '0;
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (n_out_valid) highs++;
    end
    chk("s6_no_flush", highs, 0);
    n_valid = 1'b1; n_data = 32'hE2; n_last = 1'b1; step();
    n_valid = 1'b0; n_last = 1'b0;
    chk("s6_valid", n_out_valid, 1);
    chk("s6_data", n_out_data, {32'h0, 32'hE2, 32'hE1, 32'hE0});
    chk("s6_keep", n_out_keep, 4'b0111);
    chk("s6_last", n_out_last, 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
